// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data memory responder
package mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 1024;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_HOLD = 2'd2,
    WR      = 2'd3
  } state_t;

  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/strobe_edge.sv
// rtl/strobe_edge.sv - rising-edge detector for a level-held strobe
module strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise
);

  logic prev;
  logic armed;

  // armed stays low after reset until the strobe is seen low once, so a
  // strobe still held from before reset is never taken as a new rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= strobe;
      armed <= armed | ~strobe;
    end
  end

  assign rise = strobe & ~prev & armed;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM serving one access per strobe rise
// Optional range checking with sticky memErr: define MEM_RANGE_CHECK_EN.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdMem,
  input  logic              wrMem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  output logic              busy,
  output logic              memErr
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

  logic rd_rise;
  logic wr_rise;

  strobe_edge u_rd_edge (
    .clk    (clk),
    .rst    (rst),
    .strobe (rdMem),
    .rise   (rd_rise)
  );

  strobe_edge u_wr_edge (
    .clk    (clk),
    .rst    (rst),
    .strobe (wrMem),
    .rise   (wr_rise)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              idx_oor;
  logic [IDX_W-1:0]  addr_idx;
  logic              in_range;
  logic [IDX_W-1:0]  fetch_idx;
  logic              fetch_oor;

  logic wr_go;
  logic rd_start;
  logic fetch;
  logic valid_clr;
  logic cnt_load;
  logic cnt_dec;

  assign addr_idx = IDX_W'(addr % ADDR_W'(DEPTH));

`ifdef MEM_RANGE_CHECK_EN
  assign in_range = (addr < ADDR_W'(DEPTH));
`else
  assign in_range = 1'b1;
`endif

  // with RD_LAT==1 the fetch happens on the start edge, before idx is latched
  assign fetch_idx = (state == IDLE) ? addr_idx  : idx;
  assign fetch_oor = (state == IDLE) ? ~in_range : idx_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wr_go     = 1'b0;
    rd_start  = 1'b0;
    fetch     = 1'b0;
    valid_clr = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_rise) begin
          wr_go    = 1'b1;
          state_nx = WR;
        end else if (rd_rise) begin
          rd_start = 1'b1;
          if (RD_LAT == 1) begin
            fetch    = 1'b1;
            state_nx = RD_HOLD;
          end else begin
            cnt_load = 1'b1;
            state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!rdMem) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          fetch    = 1'b1;
          state_nx = RD_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RD_HOLD: begin
        if (!rdMem) begin
          valid_clr = 1'b1;
          state_nx  = IDLE;
        end
      end
      WR: begin
        if (!wrMem) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      rdData  <= '0;
      rdValid <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
      idx_oor <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      if (fetch) begin
        rdData  <= fetch_oor ? '0 : mem[fetch_idx];
        rdValid <= 1'b1;
      end else if (valid_clr) begin
        rdValid <= 1'b0;
      end
      if (rd_start) begin
        idx     <= addr_idx;
        idx_oor <= ~in_range;
      end
      if (cnt_load) begin
        cnt <= CNT_INIT;
      end else if (cnt_dec) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // wr_go is already low while rst is held: the edge detectors are disarmed
  always_ff @(posedge clk) begin
    if (wr_go && in_range) begin
      mem[addr_idx] <= wrData;
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((wr_go || rd_start) && !in_range) begin
      err_q <= 1'b1;
    end
  end

  assign memErr = err_q;
`else
  assign memErr = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdMem = 1'b0;
  logic              wrMem = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wrData = '0;
  logic [DATA_W-1:0] rdData;
  logic              rdValid;
  logic              busy;
  logic              memErr;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rdMem   (rdMem),
    .wrMem   (wrMem),
    .addr    (addr),
    .wrData  (wrData),
    .rdData  (rdData),
    .rdValid (rdValid),
    .busy    (busy),
    .memErr  (memErr)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] last_rd = '0;
  bit                ref_err = 1'b0;
  int                cyc = 0;
  int                busy_cnt = 0;
  logic              vprev = 1'b0;
  int                n_vec = 0;
  int                n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit oor(input logic [ADDR_W-1:0] a);
`ifdef MEM_RANGE_CHECK_EN
    return a >= ADDR_W'(DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ix(input logic [ADDR_W-1:0] a);
    return int'(a % ADDR_W'(DEPTH));
  endfunction

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (rdValid && !vprev) begin
      if (sb.size() == 0) begin
        chk("unexpected_rdValid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rdData", 64'(rdData), 64'(mon_e.data));
        chk("rdValid_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
    vprev = rdValid;
  end

  task automatic end_op(input int h);
    @(posedge clk); #1;
    chk("busy_cycles", 64'(busy_cnt), 64'(h));
    chk("rdValid_after_op", 64'(rdValid), 64'd0);
    chk("memErr", 64'(memErr), 64'(ref_err));
    chk("rdData_retained", 64'(rdData), 64'(last_rd));
  endtask

  task automatic hold_strobes(input int h);
    for (int i = 0; i < h; i++) begin
      @(posedge clk); #1;
      addr   = $urandom;
      wrData = $urandom;
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int h);
    @(posedge clk); #1;
    wrMem = 1'b1; addr = a; wrData = d; busy_cnt = 0;
    if (oor(a)) ref_err = 1'b1;
    else ref_mem[ix(a)] = d;
    hold_strobes(h);
    wrMem = 1'b0;
    end_op(h);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int h);
    exp_t e;
    @(posedge clk); #1;
    rdMem = 1'b1; addr = a; busy_cnt = 0;
    if (oor(a)) ref_err = 1'b1;
    if (h >= RD_LAT) begin
      e.data  = oor(a) ? '0 : ref_mem[ix(a)];
      e.due   = cyc + RD_LAT;
      last_rd = e.data;
      sb.push_back(e);
    end
    hold_strobes(h);
    rdMem = 1'b0;
    end_op(h);
  endtask

  task automatic do_coll(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int h);
    @(posedge clk); #1;
    rdMem = 1'b1; wrMem = 1'b1; addr = a; wrData = d; busy_cnt = 0;
    if (oor(a)) ref_err = 1'b1;
    else ref_mem[ix(a)] = d;
    hold_strobes(h);
    rdMem = 1'b0; wrMem = 1'b0;
    end_op(h);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) a = a + ADDR_W'(DEPTH * $urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdData", 64'(rdData), 64'd0);
    chk("reset_rdValid", 64'(rdValid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_memErr", 64'(memErr), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) do_write(ADDR_W'(i), $urandom, 1);

    do_write(5, 32'hDEADBEEF, 2);
    do_read(5, RD_LAT + 1);
    do_write(7, 32'h11, 3);
    do_read(7, RD_LAT);
    do_coll(9, 32'hA5, 2);
    do_read(9, RD_LAT + 2);
    do_read(9, 1);
    do_read(9, RD_LAT - 1);
    do_write(1027, 32'h5, 1);
    do_read(3, RD_LAT);
    do_read(1027, RD_LAT);
    do_read(5, RD_LAT);

    // reset in the middle of a read wait, with the strobe held across it
    @(posedge clk); #1;
    rdMem = 1'b1; addr = 5;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrd_reset_rdValid", 64'(rdValid), 64'd0);
    chk("midrd_reset_busy", 64'(busy), 64'd0);
    chk("midrd_reset_rdData", 64'(rdData), 64'd0);
    chk("midrd_reset_memErr", 64'(memErr), 64'd0);
    last_rd = '0;
    ref_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    busy_cnt = 0;
    repeat (RD_LAT + 2) @(posedge clk);
    #1;
    chk("held_strobe_after_reset", 64'(busy_cnt), 64'd0);
    rdMem = 1'b0;
    @(posedge clk); #1;
    do_read(5, RD_LAT);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       do_write(rand_addr(), $urandom, $urandom_range(1, 3));
        1, 2:    do_read(rand_addr(), $urandom_range(1, RD_LAT + 3));
        default: do_coll(rand_addr(), $urandom, $urandom_range(1, 3));
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
